motion_ctrl: RTL and testbench

MOTION_CTRL -- requirements
Module: motion_ctrl

---
 rtl/motion_pkg.sv | 27 ++
 rtl/dir_fifo.sv | 69 ++++++
 rtl/motion_ctrl.sv | 158 +++++++++++++++
 tb/tb_motion_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/motion_pkg.sv
// Shared types and constants for the keyboard-driven motion controller.
package motion_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    RIGHT = 2'd1,
    DOWN  = 2'd2,
    LEFT  = 2'd3
  } dir_t;

  localparam logic [15:0] KEY_UP    = 16'h001A;
  localparam logic [15:0] KEY_RIGHT = 16'h0007;
  localparam logic [15:0] KEY_DOWN  = 16'h0016;
  localparam logic [15:0] KEY_LEFT  = 16'h0004;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FRAME = 2'd1,
    ST_ISSUE      = 2'd2
  } state_t;

  // Directions are encoded so that flipping bit 1 gives the reverse.
  function automatic dir_t opposite(input dir_t d);
    return dir_t'(d ^ 2'b10);
  endfunction

endpackage

// File: rtl/dir_fifo.sv
// Small circular FIFO of 2-bit direction commands.
// A pop on an empty FIFO is ignored, so a same-cycle push into an empty
// FIFO is stored rather than bypassed. A push while full is accepted only
// if a pop frees a slot in the same cycle.
module dir_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [1:0] din,
  input  logic       pop,
  output logic [1:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][1:0] mem_q, mem_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  wr_en, rd_en;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));
  assign dout  = mem_q[rd_ptr_q];
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (rd_en) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({wr_en, rd_en})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers, cleared to empty on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/motion_ctrl.sv
// Keyboard-driven motion controller: buffers arrow-key commands, applies
// one per video frame (with reversal filtering and edge bounce) and offers
// a single-axis step vector to the position datapath over valid/ready.
module motion_ctrl
  import motion_pkg::*;
#(
  parameter logic [9:0] STEP       = 10'd1,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [15:0] keycode,
  input  logic        frame_tick,
  input  logic        at_top,
  input  logic        at_bottom,
  input  logic        at_left,
  input  logic        at_right,
  output logic        step_valid,
  input  logic        step_ready,
  output logic [9:0]  motion_x,
  output logic [9:0]  motion_y,
  output logic [1:0]  cur_dir,
  output logic        fifo_full,
  output logic        overflow,
  output logic        frame_miss
);

  localparam logic [9:0] NEG_STEP = ~STEP + 10'd1;

  state_t      state_q, state_d;
  dir_t        cur_dir_q, cur_dir_d;
  logic [15:0] prev_key_q, prev_key_d;
  logic        overflow_q, overflow_d;
  logic        frame_miss_q, frame_miss_d;

  logic        key_vld, push, pop_req, popped;
  dir_t        key_dir, fifo_dir, cand_dir, final_dir;
  logic [1:0]  fifo_dout;
  logic        fifo_empty, fifo_full_w, edge_hit;

  // Decode the four arrow keycodes; everything else is ignored.
  always_comb begin
    key_vld = 1'b1;
    key_dir = UP;
    case (keycode)
      KEY_UP:    key_dir = UP;
      KEY_RIGHT: key_dir = RIGHT;
      KEY_DOWN:  key_dir = DOWN;
      KEY_LEFT:  key_dir = LEFT;
      default:   key_vld = 1'b0;
    endcase
  end

  // Only a keycode change enqueues, so a held key is one command.
  assign push    = key_vld & (keycode != prev_key_q);
  assign pop_req = frame_tick & (state_q != ST_ISSUE);
  assign popped  = pop_req & ~fifo_empty;

  dir_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (Clk),
    .rst_n (Reset_n),
    .push  (push),
    .din   (key_dir),
    .pop   (pop_req),
    .dout  (fifo_dout),
    .full  (fifo_full_w),
    .empty (fifo_empty)
  );

  assign fifo_dir = dir_t'(fifo_dout);

  // Candidate direction after a pop; reversals are dropped once moving.
  always_comb begin
    cand_dir = cur_dir_q;
    if (popped) begin
      if ((state_q == ST_WAIT_FRAME) && (fifo_dir == opposite(cur_dir_q)))
        cand_dir = cur_dir_q;
      else
        cand_dir = fifo_dir;
    end
  end

  // Bounce off any edge the candidate direction would push further into.
  always_comb begin
    case (cand_dir)
      UP:      edge_hit = at_top;
      RIGHT:   edge_hit = at_right;
      DOWN:    edge_hit = at_bottom;
      default: edge_hit = at_left;
    endcase
    final_dir = edge_hit ? opposite(cand_dir) : cand_dir;
  end

  // Frame-paced FSM plus sticky error flags.
  always_comb begin
    state_d      = state_q;
    cur_dir_d    = cur_dir_q;
    prev_key_d   = keycode;
    overflow_d   = overflow_q | (push & fifo_full_w & ~pop_req);
    frame_miss_d = frame_miss_q | (frame_tick & (state_q == ST_ISSUE));
    case (state_q)
      ST_IDLE: begin
        if (popped) begin
          cur_dir_d = final_dir;
          state_d   = ST_ISSUE;
        end
      end
      ST_WAIT_FRAME: begin
        if (frame_tick) begin
          cur_dir_d = final_dir;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (step_ready) state_d = ST_WAIT_FRAME;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers with asynchronous active-low reset.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= ST_IDLE;
      cur_dir_q    <= UP;
      prev_key_q   <= 16'h0000;
      overflow_q   <= 1'b0;
      frame_miss_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_dir_q    <= cur_dir_d;
      prev_key_q   <= prev_key_d;
      overflow_q   <= overflow_d;
      frame_miss_q <= frame_miss_d;
    end
  end

  // Step vector follows the held direction; zero until a direction exists.
  always_comb begin
    motion_x = 10'd0;
    motion_y = 10'd0;
    if (state_q != ST_IDLE) begin
      case (cur_dir_q)
        UP:      motion_y = NEG_STEP;
        RIGHT:   motion_x = STEP;
        DOWN:    motion_y = STEP;
        default: motion_x = NEG_STEP;
      endcase
    end
  end

  assign step_valid = (state_q == ST_ISSUE);
  assign cur_dir    = cur_dir_q;
  assign fifo_full  = fifo_full_w;
  assign overflow   = overflow_q;
  assign frame_miss = frame_miss_q;

endmodule

// File: tb/tb_motion_ctrl.sv
// Directed bench for motion_ctrl with hand-computed expectations.
module tb_motion_ctrl;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [15:0] keycode = 16'h0000;
  logic        frame_tick = 1'b0;
  logic        at_top = 1'b0, at_bottom = 1'b0, at_left = 1'b0, at_right = 1'b0;
  logic        step_ready = 1'b0;
  logic        step_valid, fifo_full, overflow, frame_miss;
  logic [9:0]  motion_x, motion_y;
  logic [1:0]  cur_dir;

  int n_chk = 0;
  int n_fail = 0;

  motion_ctrl #(.STEP(10'd1), .FIFO_DEPTH(4)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .keycode(keycode), .frame_tick(frame_tick),
    .at_top(at_top), .at_bottom(at_bottom), .at_left(at_left), .at_right(at_right),
    .step_valid(step_valid), .step_ready(step_ready),
    .motion_x(motion_x), .motion_y(motion_y), .cur_dir(cur_dir),
    .fifo_full(fifo_full), .overflow(overflow), .frame_miss(frame_miss)
  );

  always #5 Clk = ~Clk;

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic key(input logic [15:0] k);
    keycode = k;
    step();
  endtask

  task automatic frame();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic ack();
    step_ready = 1'b1;
    step();
    step_ready = 1'b0;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    #12;
    n_chk++; if (step_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", step_valid); end
    n_chk++; if ({motion_x, motion_y} !== 20'd0) begin n_fail++; $display("FAIL reset_motion got %h/%h want 0/0", motion_x, motion_y); end
    n_chk++; if (cur_dir !== 2'd0) begin n_fail++; $display("FAIL reset_dir got %0d want 0", cur_dir); end
    n_chk++; if ({fifo_full, overflow, frame_miss} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {fifo_full, overflow, frame_miss}); end
    step();
    Reset_n = 1'b1;
    step();
  endtask

  task automatic test_first_step();
    key(16'h0007);
    n_chk++; if (step_valid !== 1'b0) begin n_fail++; $display("FAIL idle_no_valid got %0b want 0", step_valid); end
    frame();
    n_chk++; if (step_valid !== 1'b1) begin n_fail++; $display("FAIL first_valid got %0b want 1", step_valid); end
    n_chk++; if (motion_x !== 10'h001 || motion_y !== 10'h000) begin n_fail++; $display("FAIL first_motion got %h/%h want 001/000", motion_x, motion_y); end
    n_chk++; if (cur_dir !== 2'd1) begin n_fail++; $display("FAIL first_dir got %0d want 1", cur_dir); end
    ack();
    n_chk++; if (step_valid !== 1'b0) begin n_fail++; $display("FAIL first_ack got %0b want 0", step_valid); end
  endtask

  task automatic test_reverse_discard();
    key(16'h0004);
    frame();
    n_chk++; if (cur_dir !== 2'd1 || motion_x !== 10'h001) begin n_fail++; $display("FAIL rev_discard got dir %0d x %h want 1/001", cur_dir, motion_x); end
    ack();
  endtask

  task automatic test_edge_bounce();
    at_right = 1'b1;
    frame();
    at_right = 1'b0;
    n_chk++; if (cur_dir !== 2'd3) begin n_fail++; $display("FAIL edge_dir got %0d want 3", cur_dir); end
    n_chk++; if (motion_x !== 10'h3FF || motion_y !== 10'h000) begin n_fail++; $display("FAIL edge_motion got %h/%h want 3FF/000", motion_x, motion_y); end
    ack();
  endtask

  task automatic test_overflow();
    logic [15:0] keys [5];
    keys = '{16'h001A, 16'h0016, 16'h0007, 16'h001A, 16'h0016};
    for (int i = 0; i < 4; i++) key(keys[i]);
    n_chk++; if (fifo_full !== 1'b1 || overflow !== 1'b0) begin n_fail++; $display("FAIL fill4 got full %0b ovf %0b want 1/0", fifo_full, overflow); end
    key(keys[4]);
    n_chk++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL overflow got %0b want 1", overflow); end
    // Full FIFO: pop UP while pushing LEFT in the same cycle.
    keycode = 16'h0004;
    frame();
    n_chk++; if (cur_dir !== 2'd0 || motion_y !== 10'h3FF) begin n_fail++; $display("FAIL pop1 got dir %0d y %h want 0/3FF", cur_dir, motion_y); end
    n_chk++; if (fifo_full !== 1'b1) begin n_fail++; $display("FAIL full_pushpop got %0b want 1", fifo_full); end
    ack();
    frame();  // DOWN is the reverse of UP and is dropped
    n_chk++; if (cur_dir !== 2'd0 || fifo_full !== 1'b0) begin n_fail++; $display("FAIL pop2 got dir %0d full %0b want 0/0", cur_dir, fifo_full); end
    ack();
    frame();
    n_chk++; if (cur_dir !== 2'd1 || motion_x !== 10'h001) begin n_fail++; $display("FAIL pop3 got dir %0d x %h want 1/001", cur_dir, motion_x); end
    ack();
    frame();
    n_chk++; if (cur_dir !== 2'd0 || motion_y !== 10'h3FF || motion_x !== 10'h000) begin n_fail++; $display("FAIL pop4 got dir %0d %h/%h want 0 000/3FF", cur_dir, motion_x, motion_y); end
    ack();
    frame();
    n_chk++; if (cur_dir !== 2'd3 || motion_x !== 10'h3FF) begin n_fail++; $display("FAIL pop5 got dir %0d x %h want 3/3FF", cur_dir, motion_x); end
    ack();
  endtask

  task automatic test_ignored_key();
    key(16'h0055);
    frame();
    n_chk++; if (step_valid !== 1'b1 || cur_dir !== 2'd3) begin n_fail++; $display("FAIL ignored_key got v %0b dir %0d want 1/3", step_valid, cur_dir); end
    ack();
  endtask

  task automatic test_push_pop_empty();
    keycode = 16'h001A;
    frame();
    n_chk++; if (cur_dir !== 2'd3 || step_valid !== 1'b1) begin n_fail++; $display("FAIL no_bypass got dir %0d v %0b want 3/1", cur_dir, step_valid); end
    ack();
    frame();
    n_chk++; if (cur_dir !== 2'd0 || motion_y !== 10'h3FF) begin n_fail++; $display("FAIL stored_push got dir %0d y %h want 0/3FF", cur_dir, motion_y); end
    ack();
  endtask

  task automatic test_frame_miss();
    frame();
    n_chk++; if (frame_miss !== 1'b0) begin n_fail++; $display("FAIL miss_early got %0b want 0", frame_miss); end
    step();
    frame();
    step();
    n_chk++; if (step_valid !== 1'b1 || motion_y !== 10'h3FF || motion_x !== 10'h000 || cur_dir !== 2'd0) begin n_fail++; $display("FAIL hold got v %0b %h/%h dir %0d want 1 000/3FF 0", step_valid, motion_x, motion_y, cur_dir); end
    n_chk++; if (frame_miss !== 1'b1) begin n_fail++; $display("FAIL frame_miss got %0b want 1", frame_miss); end
    ack();
    n_chk++; if (frame_miss !== 1'b1 || overflow !== 1'b1) begin n_fail++; $display("FAIL sticky got miss %0b ovf %0b want 1/1", frame_miss, overflow); end
  endtask

  task automatic test_reset_mid_issue();
    frame();
    key(16'h0007);  // RIGHT queued while in ISSUE
    n_chk++; if (step_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset got %0b want 1", step_valid); end
    Reset_n = 1'b0;
    #2;
    n_chk++; if (step_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset got %0b want 0", step_valid); end
    n_chk++; if ({motion_x, motion_y} !== 20'd0 || cur_dir !== 2'd0) begin n_fail++; $display("FAIL reset_outputs got %h/%h dir %0d want 0/0 0", motion_x, motion_y, cur_dir); end
    n_chk++; if ({overflow, frame_miss} !== 2'b00) begin n_fail++; $display("FAIL reset_sticky got %b want 00", {overflow, frame_miss}); end
    keycode = 16'h0000;
    step();
    Reset_n = 1'b1;
    step();
    frame();  // FIFO must be empty, so IDLE holds
    n_chk++; if (step_valid !== 1'b0 || {motion_x, motion_y} !== 20'd0) begin n_fail++; $display("FAIL fifo_cleared got v %0b %h/%h want 0 0/0", step_valid, motion_x, motion_y); end
  endtask

  task automatic test_idle_opposite();
    key(16'h0016);
    frame();
    n_chk++; if (cur_dir !== 2'd2 || motion_y !== 10'h001 || step_valid !== 1'b1) begin n_fail++; $display("FAIL idle_opp got dir %0d y %h v %0b want 2/001/1", cur_dir, motion_y, step_valid); end
    ack();
  endtask

  initial begin
    test_reset();
    test_first_step();
    test_reverse_discard();
    test_edge_bounce();
    test_overflow();
    test_ignored_key();
    test_push_pop_empty();
    test_frame_miss();
    test_reset_mid_issue();
    test_idle_opposite();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
